firebird7_in_gate1_tessent_tdr_w19_ctl: RTL and testbench
=========================================================

Name: firebird7_in_gate1_tessent_tdr_w19_ctl

Overview:
- IJTAG test data register that directly feeds the 19-bit ijtag/functional data mux in firebird7_in gate1.
- Produces the mux select and 19-bit override data, and captures 19 bits of observe data for readback.
- Sits on the IJTAG network as one scan segment of DATA_WIDTH+1 bits, with Tessent-style capture/shift/update protocol.

Parameters:
- DATA_WIDTH, 19, width of override data, capture data and shadow data register.
- RESET_DATA, 19'h0, value loaded into the data shadow register on reset.

Ports:
- ijtag_tck  input  1  test clock; the only clock. Shift/capture on rising edge, update on falling edge.
- ijtag_reset  input  1  asynchronous, active-high reset.
- ijtag_sel  input  1  segment selected by the network.
- ijtag_ce  input  1  capture enable.
- ijtag_se  input  1  shift enable.
- ijtag_ue  input  1  update enable.
- ijtag_si  input  1  scan in.
- ijtag_so  output  1  scan out.
- capture_data_in  input  DATA_WIDTH  observe data, normally the mux data_out.
- ijtag_select  output  1  mux select; 1 selects override data.
- ijtag_data_out  output  DATA_WIDTH  override data to the mux ijtag_data_in.

Behaviour:
- Shift register sr[DATA_WIDTH:0]:
  - sr[DATA_WIDTH] is the select bit.
  - sr[DATA_WIDTH-1:0] is the data field.
- Shadow registers sel_q and data_q drive ijtag_select and ijtag_data_out directly, with no combinational path from inputs.
- Reset (ijtag_reset=1, asynchronous, any time, including mid-shift or mid-update):
  - sr=0, sel_q=0, data_q=RESET_DATA.
  - ijtag_so=0.
  - The mux returns to functional path immediately.
  - Reset held blocks all capture, shift and update.
- Rising edge of ijtag_tck, priority order:
  - Capture when sel&ce: sr[DATA_WIDTH-1:0] <- capture_data_in, sr[DATA_WIDTH] <- sel_q (select readback).
  - Else shift when sel&se: sr <- {ijtag_si, sr[DATA_WIDTH:1]}. LSB exits first and MSB enters last, so a full scan load is DATA_WIDTH+1 clocks.
  - Else hold.
  - ce&se together is illegal protocol; capture wins, with no other side effect.
- Falling edge of ijtag_tck:
  - Update when sel&ue: sel_q <- sr[DATA_WIDTH], data_q <- sr[DATA_WIDTH-1:0].
  - Otherwise shadows hold.
  - Update samples sr as it stands after the preceding rising edge; ue concurrent with se updates with the post-shift value.
- ijtag_so = sr[0], updated only on the rising edge.
- Latency:
  - Shadow outputs change on the falling edge of the update cycle, half a TCK after the last shift edge.
  - Capture is visible on ijtag_so one rising edge after the capture cycle.
- Deselect (sel=0): sr and shadows hold; ijtag_so keeps its last value.
- No wrap-around or overflow: extra shift cycles simply push older bits out of ijtag_so.

Test Plan:
- Reset check: assert ijtag_reset mid-shift -> ijtag_select=0, ijtag_data_out=19'h0, ijtag_so=0 immediately, without a clock edge.
- Load and update: shift 20 bits encoding select=1, data=19'h5A5A5 (LSB first), then ue pulse -> after the falling edge ijtag_select=1, ijtag_data_out=19'h5A5A5; unchanged before that edge.
- Capture readback: with sel_q=1 and capture_data_in=19'h7FFFF, do a capture then 20 shifts -> so stream is nineteen 1s then 1 (the select bit).
- Deselected: ijtag_sel=0 with se/ce/ue toggling for 40 clocks -> sr, ijtag_select and ijtag_data_out unchanged.
- Illegal ce&se: capture_data_in=19'h00001 with both asserted -> sr data field =19'h00001 (capture wins), no shift.
- Mid-update reset: assert reset in the same half cycle as ue -> shadows stay at 0/RESET_DATA after reset release.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_tdr_w19_ctl.sv
// IJTAG test data register for the firebird7_in gate1 19-bit data mux.
// One scan segment of DATA_WIDTH+1 bits: the top bit is the mux select,
// the lower DATA_WIDTH bits are the override data. The shadow registers drive
// the mux directly. The shift register captures observe data plus the current
// select state so the network can read both back.
module firebird7_in_gate1_tessent_tdr_w19_ctl #(
  parameter int unsigned          DATA_WIDTH = 19,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                  ijtag_tck,
  input  logic                  ijtag_reset,
  input  logic                  ijtag_sel,
  input  logic                  ijtag_ce,
  input  logic                  ijtag_se,
  input  logic                  ijtag_ue,
  input  logic                  ijtag_si,
  output logic                  ijtag_so,
  input  logic [DATA_WIDTH-1:0] capture_data_in,
  output logic                  ijtag_select,
  output logic [DATA_WIDTH-1:0] ijtag_data_out
);

  // Scan segment: sr[DATA_WIDTH] is the select bit, the rest is data.
  logic [DATA_WIDTH:0]   sr;

  // Shadow registers that actually steer the mux.
  logic                  sel_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Qualified protocol strobes. Capture outranks shift, so an illegal ce&se
  // cycle behaves exactly like a plain capture.
  logic do_capture;
  logic do_shift;
  logic do_update;

  assign do_capture = ijtag_sel & ijtag_ce;
  assign do_shift   = ijtag_sel & ijtag_se & ~ijtag_ce;
  assign do_update  = ijtag_sel & ijtag_ue;

  // Capture/shift on the rising TCK edge; LSB leaves first, new bits enter at the MSB.
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      sr <= '0;
    end else if (do_capture) begin
      sr <= {sel_q, capture_data_in};
    end else if (do_shift) begin
      sr <= {ijtag_si, sr[DATA_WIDTH:1]};
    end
  end

  // Update the shadows on the falling TCK edge from the post-shift segment contents.
  always_ff @(negedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      sel_q  <= 1'b0;
      data_q <= RESET_DATA;
    end else if (do_update) begin
      sel_q  <= sr[DATA_WIDTH];
      data_q <= sr[DATA_WIDTH-1:0];
    end
  end

  // Scan out comes straight from the segment LSB, so it only moves on rising
  // edges (or reset) and holds while the segment is deselected.
  assign ijtag_so = sr[0];

  // The mux sees registered values only; no input reaches it combinationally.
  assign ijtag_select   = sel_q;
  assign ijtag_data_out = data_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w19_ctl.sv
// Directed testbench for the gate1 19-bit IJTAG TDR.
// Inputs change 1ns after each rising TCK edge, so each falling edge and the
// following rising edge both see the same stimulus.
module tb_firebird7_in_gate1_tessent_tdr_w19_ctl;

  logic        ijtag_tck;
  logic        ijtag_reset;
  logic        ijtag_sel;
  logic        ijtag_ce;
  logic        ijtag_se;
  logic        ijtag_ue;
  logic        ijtag_si;
  logic        ijtag_so;
  logic [18:0] capture_data_in;
  logic        ijtag_select;
  logic [18:0] ijtag_data_out;

  int compareCount;
  int mismatchCount;

  logic [19:0] scanGot;
  logic [19:0] pattern;

  firebird7_in_gate1_tessent_tdr_w19_ctl #(
    .DATA_WIDTH(19),
    .RESET_DATA(19'h0)
  ) dut (
    .ijtag_tck      (ijtag_tck),
    .ijtag_reset    (ijtag_reset),
    .ijtag_sel      (ijtag_sel),
    .ijtag_ce       (ijtag_ce),
    .ijtag_se       (ijtag_se),
    .ijtag_ue       (ijtag_ue),
    .ijtag_si       (ijtag_si),
    .ijtag_so       (ijtag_so),
    .capture_data_in(capture_data_in),
    .ijtag_select   (ijtag_select),
    .ijtag_data_out (ijtag_data_out)
  );

  // Free-running test clock, 10ns period, rising edges at 5, 15, 25 ...
  initial begin
    ijtag_tck = 1'b0;
    forever #5 ijtag_tck = ~ijtag_tck;
  end

  // Drive one TCK cycle of protocol inputs, then settle just past the rising edge.
  task automatic applyStimulus(input logic sel, input logic ce, input logic se,
                               input logic ue, input logic si);
    ijtag_sel = sel;
    ijtag_ce  = ce;
    ijtag_se  = se;
    ijtag_ue  = ue;
    ijtag_si  = si;
    @(posedge ijtag_tck);
    #1;
  endtask

  // Single comparison point: count it, report it if it differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Shift a full segment in, LSB first.
  task automatic shiftIn(input logic [19:0] vec);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, vec[i]);
  endtask

  // Read the whole segment out through so while shifting vec in behind it.
  task automatic scanOut(input logic [19:0] vec, output logic [19:0] got);
    for (int i = 0; i < 20; i++) begin
      got[i] = ijtag_so;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, vec[i]);
    end
  endtask

  initial begin
    compareCount    = 0;
    mismatchCount   = 0;
    ijtag_reset     = 1'b0;
    ijtag_sel       = 1'b0;
    ijtag_ce        = 1'b0;
    ijtag_se        = 1'b0;
    ijtag_ue        = 1'b0;
    ijtag_si        = 1'b0;
    capture_data_in = 19'h0;

    // Reset before any clock edge must clear everything on its own.
    #2 ijtag_reset = 1'b1;
    #1;
    checkOutput("rst_select", 32'(ijtag_select), 32'h0);
    checkOutput("rst_data", 32'(ijtag_data_out), 32'h0);
    checkOutput("rst_so", 32'(ijtag_so), 32'h0);
    @(posedge ijtag_tck);
    #1 ijtag_reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load select=1, data=5A5A5, then update.
    shiftIn({1'b1, 19'h5A5A5});
    checkOutput("load_select_preupd", 32'(ijtag_select), 32'h0);
    ijtag_se = 1'b0;
    ijtag_ue = 1'b1;
    #1;
    checkOutput("load_select_before_neg", 32'(ijtag_select), 32'h0);
    checkOutput("load_data_before_neg", 32'(ijtag_data_out), 32'h0);
    @(negedge ijtag_tck);
    #1;
    checkOutput("load_select", 32'(ijtag_select), 32'h1);
    checkOutput("load_data", 32'(ijtag_data_out), 32'h5A5A5);
    @(posedge ijtag_tck);
    #1;

    // Capture all-ones with sel_q=1, read back while loading a pattern.
    capture_data_in = 19'h7FFFF;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("cap_so_first", 32'(ijtag_so), 32'h1);
    pattern = 20'hC3A96;
    scanOut(pattern, scanGot);
    checkOutput("cap_stream", 32'(scanGot), 32'hFFFFF);
    checkOutput("cap_keeps_select", 32'(ijtag_select), 32'h1);
    checkOutput("cap_keeps_data", 32'(ijtag_data_out), 32'h5A5A5);

    // Deselected for 40 cycles with the strobes toggling: nothing may move.
    for (int i = 0; i < 40; i++) begin
      capture_data_in = 19'(i * 12345);
      applyStimulus(1'b0, i[0], i[1], i[2], i[3]);
    end
    checkOutput("desel_select", 32'(ijtag_select), 32'h1);
    checkOutput("desel_data", 32'(ijtag_data_out), 32'h5A5A5);
    checkOutput("desel_so", 32'(ijtag_so), 32'(pattern[0]));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    scanOut(20'h0, scanGot);
    checkOutput("desel_sr", 32'(scanGot), 32'(pattern));

    // Illegal ce&se: capture wins, no shift.
    capture_data_in = 19'h00001;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("illegal_so", 32'(ijtag_so), 32'h1);
    scanOut(20'h0, scanGot);
    checkOutput("illegal_sr", 32'(scanGot), 32'h80001);

    // Reset asserted mid-shift, away from any clock edge.
    capture_data_in = 19'h7FFFF;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("midshift_so_before", 32'(ijtag_so), 32'h1);
    #2 ijtag_reset = 1'b1;
    #1;
    checkOutput("midshift_rst_select", 32'(ijtag_select), 32'h0);
    checkOutput("midshift_rst_data", 32'(ijtag_data_out), 32'h0);
    checkOutput("midshift_rst_so", 32'(ijtag_so), 32'h0);
    // Reset held must block capture and update.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("rsthold_so", 32'(ijtag_so), 32'h0);
    checkOutput("rsthold_select", 32'(ijtag_select), 32'h0);
    ijtag_reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the same half cycle as ue: update must not land.
    shiftIn({1'b1, 19'h12345});
    ijtag_se    = 1'b0;
    ijtag_ue    = 1'b1;
    ijtag_reset = 1'b1;
    @(negedge ijtag_tck);
    #1;
    ijtag_reset = 1'b0;
    ijtag_ue    = 1'b0;
    checkOutput("midupd_select", 32'(ijtag_select), 32'h0);
    checkOutput("midupd_data", 32'(ijtag_data_out), 32'h0);
    @(posedge ijtag_tck);
    #1;
    checkOutput("midupd_select_later", 32'(ijtag_select), 32'h0);
    scanOut(20'h0, scanGot);
    checkOutput("midupd_sr_cleared", 32'(scanGot), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
